// File: rtl/oitf_tracker_if.sv
// Dispatch <-> OITF bundle: allocation, in-order retire, hazard check and occupancy status.
// "master" is the dispatch/write-back side and "slave" is the tracker.
interface oitf_tracker_if #(
  parameter int PTR_W   = 2,
  parameter int RFIDX_W = 5,
  parameter int XLEN    = 32
);
  logic               i_alloc_vld;
  logic               i_alloc_rdwen;
  logic [RFIDX_W-1:0] i_alloc_rdidx;
  logic [XLEN-1:0]    i_alloc_iaddr;
  logic               o_alloc_rdy;
  logic [PTR_W-1:0]   o_alloc_ptr;

  logic               i_ret_vld;
  logic [PTR_W-1:0]   o_ret_ptr;
  logic               o_ret_rdwen;
  logic [RFIDX_W-1:0] o_ret_rdidx;
  logic [XLEN-1:0]    o_ret_iaddr;

  logic               i_chk_rs1en;
  logic [RFIDX_W-1:0] i_chk_rs1idx;
  logic               i_chk_rs2en;
  logic [RFIDX_W-1:0] i_chk_rs2idx;
  logic               i_chk_rdwen;
  logic [RFIDX_W-1:0] i_chk_rdidx;
  logic               o_raw_dep;
  logic               o_waw_dep;

  logic               o_empty;
  logic               o_full;
  logic [PTR_W:0]     o_count;

  modport master (
    output i_alloc_vld, i_alloc_rdwen, i_alloc_rdidx, i_alloc_iaddr, i_ret_vld,
           i_chk_rs1en, i_chk_rs1idx, i_chk_rs2en, i_chk_rs2idx, i_chk_rdwen, i_chk_rdidx,
    input  o_alloc_rdy, o_alloc_ptr, o_ret_ptr, o_ret_rdwen, o_ret_rdidx, o_ret_iaddr,
           o_raw_dep, o_waw_dep, o_empty, o_full, o_count
  );

  modport slave (
    input  i_alloc_vld, i_alloc_rdwen, i_alloc_rdidx, i_alloc_iaddr, i_ret_vld,
           i_chk_rs1en, i_chk_rs1idx, i_chk_rs2en, i_chk_rs2idx, i_chk_rdwen, i_chk_rdidx,
    output o_alloc_rdy, o_alloc_ptr, o_ret_ptr, o_ret_rdwen, o_ret_rdidx, o_ret_iaddr,
           o_raw_dep, o_waw_dep, o_empty, o_full, o_count
  );
endinterface

// File: rtl/oitf_tracker.sv
// Outstanding Instruction Track FIFO: records long-cycle instructions at dispatch, retires them
// in order on write-back, and flags RAW/WAW hazards against destinations still in flight.
module oitf_tracker #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int RFIDX_W = 5,
  parameter int XLEN    = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  oitf_tracker_if.slave  bus
);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0]     wptr_q, wptr_d;
  logic [PTR_W:0]     rptr_q, rptr_d;
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [DEPTH-1:0]   rdwen_q;
  logic [RFIDX_W-1:0] rdidx_q [DEPTH];
  logic [XLEN-1:0]    iaddr_q [DEPTH];

  logic [PTR_W-1:0]   widx, ridx;
  logic               empty, full, alloc_fire, ret_fire;
  logic               raw_dep, waw_dep, live;

  assign widx  = wptr_q[PTR_W-1:0];
  assign ridx  = rptr_q[PTR_W-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (widx == ridx) && (wptr_q[PTR_W] != rptr_q[PTR_W]);

  // Full blocks alloc even if the head retires this cycle: no same-cycle bypass.
  assign alloc_fire = bus.i_alloc_vld & ~full;
  assign ret_fire   = bus.i_ret_vld & ~empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    vld_d  = vld_q;
    if (alloc_fire) begin
      vld_d[widx] = 1'b1;
      wptr_d      = wptr_q + PTR_ONE;
    end
    if (ret_fire) begin
      vld_d[ridx] = 1'b0;
      rptr_d      = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      vld_q  <= vld_d;
    end
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (alloc_fire) begin
      rdwen_q[widx] <= bus.i_alloc_rdwen;
      rdidx_q[widx] <= bus.i_alloc_rdidx;
      iaddr_q[widx] <= bus.i_alloc_iaddr;
    end
  end

  // Only registered entries are compared, so a same-cycle allocation is invisible while a
  // same-cycle retirement still counts.
  always_comb begin
    raw_dep = 1'b0;
    waw_dep = 1'b0;
    live    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live = vld_q[i] & rdwen_q[i] & (rdidx_q[i] != '0);
      if (live && bus.i_chk_rs1en && (rdidx_q[i] == bus.i_chk_rs1idx)) raw_dep = 1'b1;
      if (live && bus.i_chk_rs2en && (rdidx_q[i] == bus.i_chk_rs2idx)) raw_dep = 1'b1;
      if (live && bus.i_chk_rdwen && (rdidx_q[i] == bus.i_chk_rdidx))  waw_dep = 1'b1;
    end
  end

  assign bus.o_alloc_rdy = ~full;
  assign bus.o_alloc_ptr = widx;
  assign bus.o_ret_ptr   = ridx;
  assign bus.o_ret_rdwen = ~empty & rdwen_q[ridx];
  assign bus.o_ret_rdidx = rdidx_q[ridx];
  assign bus.o_ret_iaddr = iaddr_q[ridx];
  assign bus.o_raw_dep   = raw_dep;
  assign bus.o_waw_dep   = waw_dep;
  assign bus.o_empty     = empty;
  assign bus.o_full      = full;
  assign bus.o_count     = wptr_q - rptr_q;
endmodule

// File: tb/tb_oitf_tracker.sv
// Directed bench for oitf_tracker: fill/drain, hazard detection, concurrent alloc+retire with
// pointer wrap, full-with-retire, and mid-operation reset.
module tb_oitf_tracker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  oitf_tracker_if #(.PTR_W(2), .RFIDX_W(5), .XLEN(32)) bus ();

  oitf_tracker #(.DEPTH(4), .PTR_W(2), .RFIDX_W(5), .XLEN(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_alloc_vld   = 1'b0;
    bus.i_alloc_rdwen = 1'b0;
    bus.i_alloc_rdidx = '0;
    bus.i_alloc_iaddr = '0;
    bus.i_ret_vld     = 1'b0;
    bus.i_chk_rs1en   = 1'b0;
    bus.i_chk_rs1idx  = '0;
    bus.i_chk_rs2en   = 1'b0;
    bus.i_chk_rs2idx  = '0;
    bus.i_chk_rdwen   = 1'b0;
    bus.i_chk_rdidx   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_chk_rs1en = 1'b1; bus.i_chk_rs1idx = 5'd5;
    bus.i_chk_rdwen = 1'b1; bus.i_chk_rdidx  = 5'd5;
    #1;
    total_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL rst_empty: got %0b want 1", bus.o_empty); else pass_cnt++;
    total_cnt++; if (bus.o_full !== 1'b0) $display("FAIL rst_full: got %0b want 0", bus.o_full); else pass_cnt++;
    total_cnt++; if (bus.o_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", bus.o_count); else pass_cnt++;
    total_cnt++; if (bus.o_alloc_rdy !== 1'b1) $display("FAIL rst_rdy: got %0b want 1", bus.o_alloc_rdy); else pass_cnt++;
    total_cnt++; if (bus.o_alloc_ptr !== 2'd0) $display("FAIL rst_alloc_ptr: got %0d want 0", bus.o_alloc_ptr); else pass_cnt++;
    total_cnt++; if (bus.o_ret_ptr !== 2'd0) $display("FAIL rst_ret_ptr: got %0d want 0", bus.o_ret_ptr); else pass_cnt++;
    total_cnt++; if (bus.o_ret_rdwen !== 1'b0) $display("FAIL rst_ret_rdwen: got %0b want 0", bus.o_ret_rdwen); else pass_cnt++;
    total_cnt++; if (bus.o_raw_dep !== 1'b0 || bus.o_waw_dep !== 1'b0)
      $display("FAIL rst_hazard: got raw=%0b waw=%0b want 0/0", bus.o_raw_dep, bus.o_waw_dep); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_fill();
    bus.i_alloc_vld   = 1'b1;
    bus.i_alloc_rdwen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_alloc_rdidx = 5'(5 + i);
      bus.i_alloc_iaddr = 32'h100 + 32'(4 * i);
      #1;
      total_cnt++; if (bus.o_alloc_ptr !== 2'(i)) $display("FAIL fill_ptr%0d: got %0d want %0d", i, bus.o_alloc_ptr, i); else pass_cnt++;
      tick();
      total_cnt++; if (bus.o_count !== 3'(i + 1)) $display("FAIL fill_count%0d: got %0d want %0d", i, bus.o_count, i + 1); else pass_cnt++;
    end
    total_cnt++; if (bus.o_full !== 1'b1) $display("FAIL fill_full: got %0b want 1", bus.o_full); else pass_cnt++;
    total_cnt++; if (bus.o_alloc_rdy !== 1'b0) $display("FAIL fill_rdy: got %0b want 0", bus.o_alloc_rdy); else pass_cnt++;
    bus.i_alloc_rdidx = 5'd9;
    bus.i_alloc_iaddr = 32'h200;
    tick();
    total_cnt++; if (bus.o_count !== 3'd4) $display("FAIL fill_overflow_count: got %0d want 4", bus.o_count); else pass_cnt++;
    total_cnt++; if (bus.o_ret_rdidx !== 5'd5) $display("FAIL fill_overflow_head: got %0d want 5", bus.o_ret_rdidx); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_retire();
    bus.i_ret_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (bus.o_ret_rdidx !== 5'(5 + i)) $display("FAIL ret_rdidx%0d: got %0d want %0d", i, bus.o_ret_rdidx, 5 + i); else pass_cnt++;
      total_cnt++; if (bus.o_ret_ptr !== 2'(i)) $display("FAIL ret_ptr%0d: got %0d want %0d", i, bus.o_ret_ptr, i); else pass_cnt++;
      total_cnt++; if (bus.o_ret_iaddr !== 32'h100 + 32'(4 * i))
        $display("FAIL ret_iaddr%0d: got %0h want %0h", i, bus.o_ret_iaddr, 32'h100 + 32'(4 * i)); else pass_cnt++;
      total_cnt++; if (bus.o_ret_rdwen !== 1'b1) $display("FAIL ret_rdwen%0d: got %0b want 1", i, bus.o_ret_rdwen); else pass_cnt++;
      tick();
    end
    total_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL ret_empty: got %0b want 1", bus.o_empty); else pass_cnt++;
    total_cnt++; if (bus.o_ret_rdwen !== 1'b0) $display("FAIL ret_empty_rdwen: got %0b want 0", bus.o_ret_rdwen); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_count !== 3'd0) $display("FAIL ret_underflow_count: got %0d want 0", bus.o_count); else pass_cnt++;
    total_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL ret_underflow_empty: got %0b want 1", bus.o_empty); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_hazard();
    bus.i_alloc_vld = 1'b1; bus.i_alloc_rdwen = 1'b1; bus.i_alloc_rdidx = 5'd5;
    bus.i_chk_rs1en = 1'b1; bus.i_chk_rs1idx = 5'd5;
    #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b0) $display("FAIL haz_alloc_same_cycle: got %0b want 0", bus.o_raw_dep); else pass_cnt++;
    tick();
    bus.i_alloc_vld = 1'b0;
    #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b1) $display("FAIL haz_raw_rs1: got %0b want 1", bus.o_raw_dep); else pass_cnt++;
    bus.i_chk_rs1idx = 5'd6; #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b0) $display("FAIL haz_raw_nomatch: got %0b want 0", bus.o_raw_dep); else pass_cnt++;
    bus.i_chk_rs1en = 1'b0; bus.i_chk_rs2en = 1'b1; bus.i_chk_rs2idx = 5'd5; #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b1) $display("FAIL haz_raw_rs2: got %0b want 1", bus.o_raw_dep); else pass_cnt++;
    bus.i_chk_rs2en = 1'b0; bus.i_chk_rs1idx = 5'd5; #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b0) $display("FAIL haz_raw_disabled: got %0b want 0", bus.o_raw_dep); else pass_cnt++;
    bus.i_chk_rdwen = 1'b1; bus.i_chk_rdidx = 5'd5; #1;
    total_cnt++; if (bus.o_waw_dep !== 1'b1) $display("FAIL haz_waw: got %0b want 1", bus.o_waw_dep); else pass_cnt++;
    bus.i_chk_rdwen = 1'b0; #1;
    total_cnt++; if (bus.o_waw_dep !== 1'b0) $display("FAIL haz_waw_disabled: got %0b want 0", bus.o_waw_dep); else pass_cnt++;
    bus.i_chk_rs1en = 1'b1; bus.i_ret_vld = 1'b1; #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b1) $display("FAIL haz_retiring_counts: got %0b want 1", bus.o_raw_dep); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_raw_dep !== 1'b0) $display("FAIL haz_after_retire: got %0b want 0", bus.o_raw_dep); else pass_cnt++;
    idle_inputs();
    bus.i_alloc_vld = 1'b1; bus.i_alloc_rdwen = 1'b1; bus.i_alloc_rdidx = 5'd0;
    tick();
    bus.i_alloc_rdwen = 1'b0; bus.i_alloc_rdidx = 5'd7;
    tick();
    bus.i_alloc_vld = 1'b0;
    bus.i_chk_rs1en = 1'b1; bus.i_chk_rs1idx = 5'd0;
    bus.i_chk_rdwen = 1'b1; bus.i_chk_rdidx = 5'd0;
    #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b0 || bus.o_waw_dep !== 1'b0)
      $display("FAIL haz_x0: got raw=%0b waw=%0b want 0/0", bus.o_raw_dep, bus.o_waw_dep); else pass_cnt++;
    bus.i_chk_rs1idx = 5'd7; bus.i_chk_rdidx = 5'd7; #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b0 || bus.o_waw_dep !== 1'b0)
      $display("FAIL haz_no_rdwen: got raw=%0b waw=%0b want 0/0", bus.o_raw_dep, bus.o_waw_dep); else pass_cnt++;
    idle_inputs();
  endtask

  // Entries allocated here carry rd = 10,11,12,... in allocation order.
  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.i_alloc_vld = 1'b1; bus.i_alloc_rdwen = 1'b1;
    bus.i_alloc_rdidx = 5'd10; tick();
    bus.i_alloc_rdidx = 5'd11; tick();
    bus.i_ret_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.i_alloc_rdidx = 5'(12 + k);
      #1;
      total_cnt++; if (bus.o_alloc_ptr !== 2'((2 + k) % 4)) $display("FAIL b2b_alloc_ptr%0d: got %0d want %0d", k, bus.o_alloc_ptr, (2 + k) % 4); else pass_cnt++;
      total_cnt++; if (bus.o_ret_ptr !== 2'(k)) $display("FAIL b2b_ret_ptr%0d: got %0d want %0d", k, bus.o_ret_ptr, k); else pass_cnt++;
      total_cnt++; if (bus.o_ret_rdidx !== 5'(10 + k)) $display("FAIL b2b_ret_rdidx%0d: got %0d want %0d", k, bus.o_ret_rdidx, 10 + k); else pass_cnt++;
      tick();
      total_cnt++; if (bus.o_count !== 3'd2) $display("FAIL b2b_count%0d: got %0d want 2", k, bus.o_count); else pass_cnt++;
    end
    total_cnt++; if (bus.o_alloc_ptr !== 2'd1) $display("FAIL b2b_alloc_ptr_wrap: got %0d want 1", bus.o_alloc_ptr); else pass_cnt++;
    total_cnt++; if (bus.o_ret_ptr !== 2'd3) $display("FAIL b2b_ret_ptr_end: got %0d want 3", bus.o_ret_ptr); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_full_simul();
    bus.i_alloc_vld = 1'b1; bus.i_alloc_rdwen = 1'b1;
    bus.i_alloc_rdidx = 5'd15; tick();
    bus.i_alloc_rdidx = 5'd16; tick();
    total_cnt++; if (bus.o_full !== 1'b1) $display("FAIL full_wrapped: got %0b want 1", bus.o_full); else pass_cnt++;
    bus.i_alloc_rdidx = 5'd17; bus.i_ret_vld = 1'b1;
    #1;
    total_cnt++; if (bus.o_alloc_rdy !== 1'b0) $display("FAIL full_rdy_with_ret: got %0b want 0", bus.o_alloc_rdy); else pass_cnt++;
    tick();
    total_cnt++; if (bus.o_count !== 3'd3) $display("FAIL full_simul_count: got %0d want 3", bus.o_count); else pass_cnt++;
    total_cnt++; if (bus.o_alloc_ptr !== 2'd3) $display("FAIL full_simul_alloc_ptr: got %0d want 3", bus.o_alloc_ptr); else pass_cnt++;
    total_cnt++; if (bus.o_ret_rdidx !== 5'd14) $display("FAIL full_simul_head: got %0d want 14", bus.o_ret_rdidx); else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.i_chk_rs1en = 1'b1; bus.i_chk_rs1idx = 5'd14;
    bus.i_chk_rdwen = 1'b1; bus.i_chk_rdidx  = 5'd16;
    #1;
    total_cnt++; if (bus.o_raw_dep !== 1'b1 || bus.o_waw_dep !== 1'b1)
      $display("FAIL mid_pre_hazard: got raw=%0b waw=%0b want 1/1", bus.o_raw_dep, bus.o_waw_dep); else pass_cnt++;
    rst = 1'b1; tick(); rst = 1'b0; #1;
    total_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL mid_empty: got %0b want 1", bus.o_empty); else pass_cnt++;
    total_cnt++; if (bus.o_count !== 3'd0) $display("FAIL mid_count: got %0d want 0", bus.o_count); else pass_cnt++;
    total_cnt++; if (bus.o_ret_rdwen !== 1'b0) $display("FAIL mid_ret_rdwen: got %0b want 0", bus.o_ret_rdwen); else pass_cnt++;
    total_cnt++; if (bus.o_raw_dep !== 1'b0 || bus.o_waw_dep !== 1'b0)
      $display("FAIL mid_hazard: got raw=%0b waw=%0b want 0/0", bus.o_raw_dep, bus.o_waw_dep); else pass_cnt++;
    total_cnt++; if (bus.o_alloc_ptr !== 2'd0) $display("FAIL mid_alloc_ptr: got %0d want 0", bus.o_alloc_ptr); else pass_cnt++;
    total_cnt++; if (bus.o_ret_ptr !== 2'd0) $display("FAIL mid_ret_ptr: got %0d want 0", bus.o_ret_ptr); else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_retire();
    test_hazard();
    test_back_to_back();
    test_full_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
